// File: rtl/serial_word_accumulator.sv
// Purpose: bit-serial multi-operand adder (mod 2^WIDTH) using one 1-bit full-adder cell and a registered carry.
// Latency: an operand accepted at edge t occupies WIDTH ADD cycles; in_ready (non-last) or out_valid (last) is high after edge t+WIDTH.
// Backpressure: in_ready is low through ADD and DONE; DONE holds out_sum/out_carry stable until out_ready.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_data/in_last operand stream;
//        out_valid/out_ready/out_sum/out_carry result; out_nops only when SERIAL_ACC_OPCOUNT_EN is defined.
// Optional macro SERIAL_ACC_OPCOUNT_EN adds a saturating per-sum operand counter on out_nops.
module serial_word_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef SERIAL_ACC_OPCOUNT_EN
  ,
  output logic [7:0]       out_nops
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_sr_q, op_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
`ifdef SERIAL_ACC_OPCOUNT_EN
  logic [7:0]       nops_q, nops_d;
`endif

  // The single full-adder cell: operand LSB, accumulator LSB, registered carry.
  logic fa_a, fa_b, fa_c, fa_s, fa_co;
  assign fa_a  = op_sr_q[0];
  assign fa_b  = acc_q[0];
  assign fa_c  = carry_q;
  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_b & fa_c) | (fa_a & fa_c);

  always_comb begin
    state_d   = state_q;
    op_sr_d   = op_sr_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    sticky_d  = sticky_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
`ifdef SERIAL_ACC_OPCOUNT_EN
    nops_d    = nops_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_sr_d   = in_data;
          last_d    = in_last;
          carry_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = ADD;
`ifdef SERIAL_ACC_OPCOUNT_EN
          if (nops_q != 8'hFF) nops_d = nops_q + 8'd1;
`endif
        end
      end

      ADD: begin
        // Both registers rotate through the adder LSB-first; after WIDTH
        // shifts the sum bits have walked all the way down into place.
        carry_d   = fa_co;
        op_sr_d   = {1'b0, op_sr_q[WIDTH-1:1]};
        acc_d     = {fa_s, acc_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          // Carry out of the MSB for this operand feeds the sticky flag.
          sticky_d = sticky_q | fa_co;
          state_d  = last_q ? DONE : IDLE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Clearing here lets the next sum start from zero with no extra gap.
          acc_d    = '0;
          sticky_d = 1'b0;
`ifdef SERIAL_ACC_OPCOUNT_EN
          nops_d   = 8'd0;
`endif
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_sr_q   <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      sticky_q  <= 1'b0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
`ifdef SERIAL_ACC_OPCOUNT_EN
      nops_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      op_sr_q   <= op_sr_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      sticky_q  <= sticky_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
`ifdef SERIAL_ACC_OPCOUNT_EN
      nops_q    <= nops_d;
`endif
    end
  end

  // out_sum mirrors the accumulator; only meaningful while out_valid is high.
  assign out_sum   = acc_q;
  assign out_carry = sticky_q;
`ifdef SERIAL_ACC_OPCOUNT_EN
  assign out_nops  = nops_q;
`endif

endmodule
